voter_tally_seq: RTL and testbench
==================================

// Module: voter_tally_seq
// PURPOSE
//  Sequential, parametrised vote tallier: collects one yes/no ballot per voter over a handshake,
//  rejects duplicate and out-of-range ballots, and closes the session on all-voted, on an explicit
//  close request or on timeout. Produces a one-hot pass/tie/fail verdict with a quorum check.
//  It sits between ballot sources and downstream control logic that consumes the verdict.
// PARAMETERS
//  N_VOTERS  4    number of voters, >=2; voter ids 0..N_VOTERS-1
//  QUORUM    3    minimum ballots cast for a valid verdict, 1..N_VOTERS
//  MODE      0    0 = simple majority (yes>no), 1 = unanimous (yes==N_VOTERS), 2 = threshold (yes>=K_YES)
//  K_YES     3    yes count needed in MODE 2, 1..N_VOTERS
//  TIMEOUT   64   cycles in OPEN with no accepted ballot before auto-close; 0 disables the timeout
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         synchronous, active-high reset
//  start         in   1         pulse: open a new session (honoured in IDLE and DONE only)
//  close         in   1         pulse: force the session to close (honoured in OPEN only)
//  vote_valid    in   1         ballot present
//  vote_id       in   ID_W      voter id, ID_W = $clog2(N_VOTERS), min 1
//  vote_yes      in   1         1 = yes, 0 = no
//  vote_ready    out  1         ballot accepted when vote_valid && vote_ready
//  vote_err      out  1         1-cycle pulse: handshaked ballot rejected (duplicate or id>=N_VOTERS)
//  yes_cnt       out  CNT_W     running yes tally, CNT_W = $clog2(N_VOTERS+1)
//  no_cnt        out  CNT_W     running no tally
//  result_valid  out  1         held high in DONE
//  result        out  3         one-hot verdict: [2] pass, [1] tie, [0] fail; 0 while !result_valid
//  no_quorum     out  1         valid with result: fewer than QUORUM ballots were cast
// BEHAVIOUR
//  - Reset: state=IDLE; vote_ready=0, vote_err=0, yes_cnt=0, no_cnt=0, result_valid=0, result=0,
//    no_quorum=0; voted bitmap and timeout counter cleared. Reset mid-session discards all ballots.
//  - FSM IDLE -> (start) OPEN -> (all voted | close | timeout) EVAL -> (1 cycle) DONE -> (start) OPEN.
//  - Entering OPEN clears the counts, bitmap, result, result_valid and no_quorum, all in the cycle start is sampled.
//  - vote_ready = 1 only in OPEN (registered state). A handshake with id<N_VOTERS and bitmap[id]=0
//    sets bitmap[id] and increments yes_cnt or no_cnt; the new count is visible the next cycle.
//    A handshake with a duplicate or out-of-range id changes no count; vote_err=1 the next cycle.
//  - All voted: the cycle after the N_VOTERS-th accepted ballot, state=EVAL.
//  - close and an accepted ballot in the same cycle: the ballot is counted, then the session closes.
//  - Timeout: the counter resets on each accepted ballot and on entry to OPEN. At TIMEOUT it closes
//    the session exactly like close.
//  - EVAL (1 cycle): cast=yes+no; no_quorum=(cast<QUORUM). If no_quorum, result=001.
//    MODE 0: yes>no->100, yes==no->010, else 001. MODE 1: yes==N_VOTERS->100, else 001.
//    MODE 2: yes>=K_YES->100, else 001; tie is never reported in modes 1/2.
//  - DONE: result and result_valid are registered, stable until the next start or rst.
//    Latency: close sampled at cycle t -> result_valid=1 at t+2.
//  - start in OPEN/EVAL, close outside OPEN, and ballots outside OPEN are ignored (no vote_err).
//  - Counters never overflow: CNT_W holds N_VOTERS; all compares are unsigned at CNT_W+1 bits.
// STRUCTURE
//  - Shared package voter_pkg: state enum {IDLE, OPEN, EVAL, DONE}, MODE_MAJ/MODE_UNAN/MODE_THR
//    constants, RES_PASS=3'b100, RES_TIE=3'b010, RES_FAIL=3'b001.
//  - One sub-module, voter_verdict: purely combinational yes/no/mode -> result/no_quorum.
//    The top level owns the FSM, the bitmap, the counters and the timeout.
// TESTING
//  1. N=4, MODE 0: start; ids 0,1,2 yes, id 3 no -> auto-close; result=100, yes=3, no=1, no_quorum=0.
//  2. MODE 0: ids 0,1 yes, ids 2,3 no -> result=010; repeat id 1 mid-session -> vote_err pulse, yes_cnt unchanged.
//  3. QUORUM=3: ids 0,1 yes, then close -> result=001, no_quorum=1, result_valid exactly 2 cycles after close.
//  4. TIMEOUT=8: start, one ballot, then idle -> result_valid rises after 8 idle cycles in OPEN + EVAL.
//  5. MODE 1 with 4 yes -> 100; MODE 1 with 3 yes, 1 no -> 001; MODE 2, K_YES=2, 2 yes + 2 no -> 100.
//  6. rst asserted mid-OPEN after 2 ballots -> all outputs 0 next cycle; ballot ignored until the next start; vote_id=5 with N=5 -> vote_err.

Source files
------------

// File: rtl/voter_pkg.sv
// Shared types and constants for the voter tally block: session states, voting modes
// and the one-hot verdict encodings.
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MODE_MAJ  = 0;
  localparam int MODE_UNAN = 1;
  localparam int MODE_THR  = 2;

  localparam logic [2:0] RES_PASS = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_FAIL = 3'b001;

endpackage

// File: rtl/voter_verdict.sv
// Combinational verdict: turns the final yes/no tallies into a one-hot pass/tie/fail
// result plus a quorum flag, according to the voting mode.
module voter_verdict
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int QUORUM   = 3,
  parameter int MODE     = MODE_MAJ,
  parameter int K_YES    = 3,
  parameter int CNT_W    = 3
) (
  input  logic [CNT_W-1:0] yes_i,
  input  logic [CNT_W-1:0] no_i,
  output logic [2:0]       result_o,
  output logic             no_quorum_o
);

  localparam int CW = CNT_W + 1;

  logic [CW-1:0] yesWide;
  logic [CW-1:0] noWide;
  logic [CW-1:0] castWide;
  logic          belowQuorum;

  // One extra bit keeps yes+no and every compare free of wrap-around.
  always_comb begin
    yesWide     = {1'b0, yes_i};
    noWide      = {1'b0, no_i};
    castWide    = yesWide + noWide;
    belowQuorum = (castWide < CW'(QUORUM));
    result_o    = RES_FAIL;
    if (!belowQuorum) begin
      case (MODE)
        MODE_MAJ: begin
          if (yesWide > noWide)       result_o = RES_PASS;
          else if (yesWide == noWide) result_o = RES_TIE;
          else                        result_o = RES_FAIL;
        end
        MODE_UNAN: begin
          if (yesWide == CW'(N_VOTERS)) result_o = RES_PASS;
        end
        default: begin
          if (yesWide >= CW'(K_YES)) result_o = RES_PASS;
        end
      endcase
    end
    no_quorum_o = belowQuorum;
  end

endmodule

// File: rtl/voter_tally_seq.sv
// Sequential vote tallier: accepts one ballot per voter while a session is open, rejects
// duplicates and unknown ids, and closes on all-voted, explicit close or inactivity timeout.
module voter_tally_seq
  import voter_pkg::*;
#(
  parameter int N_VOTERS = 4,
  parameter int QUORUM   = 3,
  parameter int MODE     = MODE_MAJ,
  parameter int K_YES    = 3,
  parameter int TIMEOUT  = 64,
  localparam int ID_W    = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1,
  localparam int CNT_W   = $clog2(N_VOTERS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             close_i,
  input  logic             vote_valid_i,
  input  logic [ID_W-1:0]  vote_id_i,
  input  logic             vote_yes_i,
  output logic             vote_ready_o,
  output logic             vote_err_o,
  output logic [CNT_W-1:0] yes_cnt_o,
  output logic [CNT_W-1:0] no_cnt_o,
  output logic             result_valid_o,
  output logic [2:0]       result_o,
  output logic             no_quorum_o
);

  localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e              state_q;
  logic [N_VOTERS-1:0] votedMap_q, votedMap_d;
  logic [CNT_W-1:0]    yesCnt_q, yesCnt_d;
  logic [CNT_W-1:0]    noCnt_q, noCnt_d;
  logic [TMO_W-1:0]    tmoCnt_q;
  logic                voteErr_q;
  logic                resultValid_q;
  logic [2:0]          result_q;
  logic                noQuorum_q;

  logic                handshake;
  logic                inRange;
  logic                accept;
  logic                allVoted;
  logic                timeoutHit;
  logic [CNT_W:0]      castNext;
  logic [2:0]          verdict;
  logic                verdictNoQuorum;

  // Ballot acceptance: only in OPEN, only for known ids that have not voted yet.
  always_comb begin
    handshake  = vote_valid_i && (state_q == OPEN);
    inRange    = ({1'b0, vote_id_i} < (ID_W + 1)'(N_VOTERS));
    accept     = handshake && inRange && !votedMap_q[vote_id_i];
    castNext   = {1'b0, yesCnt_q} + {1'b0, noCnt_q} + (CNT_W + 1)'(1);
    allVoted   = accept && (castNext == (CNT_W + 1)'(N_VOTERS));
    timeoutHit = (TIMEOUT != 0) && !accept && (tmoCnt_q == TMO_W'(TMO_LAST));
    votedMap_d = votedMap_q;
    yesCnt_d   = yesCnt_q;
    noCnt_d    = noCnt_q;
    if (accept) begin
      votedMap_d[vote_id_i] = 1'b1;
      if (vote_yes_i) yesCnt_d = yesCnt_q + CNT_W'(1);
      else            noCnt_d  = noCnt_q + CNT_W'(1);
    end
  end

  voter_verdict #(
    .N_VOTERS (N_VOTERS),
    .QUORUM   (QUORUM),
    .MODE     (MODE),
    .K_YES    (K_YES),
    .CNT_W    (CNT_W)
  ) u_verdict (
    .yes_i       (yesCnt_q),
    .no_i        (noCnt_q),
    .result_o    (verdict),
    .no_quorum_o (verdictNoQuorum)
  );

  // Session FSM; the verdict is captured during the single EVAL cycle and held in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      votedMap_q    <= '0;
      yesCnt_q      <= '0;
      noCnt_q       <= '0;
      tmoCnt_q      <= '0;
      voteErr_q     <= 1'b0;
      resultValid_q <= 1'b0;
      result_q      <= '0;
      noQuorum_q    <= 1'b0;
    end else begin
      voteErr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q       <= OPEN;
            votedMap_q    <= '0;
            yesCnt_q      <= '0;
            noCnt_q       <= '0;
            tmoCnt_q      <= '0;
            resultValid_q <= 1'b0;
            result_q      <= '0;
            noQuorum_q    <= 1'b0;
          end
        end
        OPEN: begin
          voteErr_q  <= handshake && !accept;
          votedMap_q <= votedMap_d;
          yesCnt_q   <= yesCnt_d;
          noCnt_q    <= noCnt_d;
          tmoCnt_q   <= accept ? '0 : tmoCnt_q + TMO_W'(1);
          if (allVoted || close_i || timeoutHit) state_q <= EVAL;
        end
        EVAL: begin
          result_q      <= verdict;
          noQuorum_q    <= verdictNoQuorum;
          resultValid_q <= 1'b1;
          state_q       <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_ready_o   = (state_q == OPEN);
  assign vote_err_o     = voteErr_q;
  assign yes_cnt_o      = yesCnt_q;
  assign no_cnt_o       = noCnt_q;
  assign result_valid_o = resultValid_q;
  assign result_o       = result_q;
  assign no_quorum_o    = noQuorum_q;

endmodule

// File: tb/tb_voter_tally_seq.sv
// Directed bench for voter_tally_seq: three N=4 instances (majority, unanimous, threshold)
// share one ballot stream; a fourth N=5 instance covers out-of-range ids and reset.
module tb_voter_tally_seq;
  import voter_pkg::*;

  logic clk;
  logic rst;

  logic       start, closeReq, vValid, vYes;
  logic [1:0] vId;
  logic       startD, closeD, vValidD, vYesD;
  logic [2:0] vIdD;

  logic       readyA, errA, rvA, nqA;
  logic [2:0] yesA, noA, resA;
  logic       readyB, errB, rvB, nqB;
  logic [2:0] yesB, noB, resB;
  logic       readyC, errC, rvC, nqC;
  logic [2:0] yesC, noC, resC;
  logic       readyD, errD, rvD, nqD;
  logic [2:0] yesD, noD, resD;

  int checks = 0;
  int errors = 0;

  voter_tally_seq #(.N_VOTERS(4), .QUORUM(3), .MODE(MODE_MAJ), .K_YES(3), .TIMEOUT(8)) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(start), .close_i(closeReq),
    .vote_valid_i(vValid), .vote_id_i(vId), .vote_yes_i(vYes),
    .vote_ready_o(readyA), .vote_err_o(errA), .yes_cnt_o(yesA), .no_cnt_o(noA),
    .result_valid_o(rvA), .result_o(resA), .no_quorum_o(nqA));

  voter_tally_seq #(.N_VOTERS(4), .QUORUM(3), .MODE(MODE_UNAN), .K_YES(3), .TIMEOUT(64)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(start), .close_i(closeReq),
    .vote_valid_i(vValid), .vote_id_i(vId), .vote_yes_i(vYes),
    .vote_ready_o(readyB), .vote_err_o(errB), .yes_cnt_o(yesB), .no_cnt_o(noB),
    .result_valid_o(rvB), .result_o(resB), .no_quorum_o(nqB));

  voter_tally_seq #(.N_VOTERS(4), .QUORUM(3), .MODE(MODE_THR), .K_YES(2), .TIMEOUT(64)) dutC (
    .clk_i(clk), .rst_i(rst), .start_i(start), .close_i(closeReq),
    .vote_valid_i(vValid), .vote_id_i(vId), .vote_yes_i(vYes),
    .vote_ready_o(readyC), .vote_err_o(errC), .yes_cnt_o(yesC), .no_cnt_o(noC),
    .result_valid_o(rvC), .result_o(resC), .no_quorum_o(nqC));

  voter_tally_seq #(.N_VOTERS(5), .QUORUM(3), .MODE(MODE_MAJ), .K_YES(3), .TIMEOUT(0)) dutD (
    .clk_i(clk), .rst_i(rst), .start_i(startD), .close_i(closeD),
    .vote_valid_i(vValidD), .vote_id_i(vIdD), .vote_yes_i(vYesD),
    .vote_ready_o(readyD), .vote_err_o(errD), .yes_cnt_o(yesD), .no_cnt_o(noD),
    .result_valid_o(rvD), .result_o(resD), .no_quorum_o(nqD));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] id, input logic yes, input logic withClose);
    vValid   = 1'b1;
    vId      = id;
    vYes     = yes;
    closeReq = withClose;
    tick();
    vValid   = 1'b0;
    closeReq = 1'b0;
  endtask

  task automatic applyStimulusD(input logic [2:0] id, input logic yes);
    vValidD = 1'b1;
    vIdD    = id;
    vYesD   = yes;
    tick();
    vValidD = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; closeReq = 1'b0; vValid = 1'b0; vId = '0; vYes = 1'b0;
    startD = 1'b0; closeD = 1'b0; vValidD = 1'b0; vIdD = '0; vYesD = 1'b0;
    tick();
    tick();
    checkOutput("reset.ready", int'(readyA), 0);
    checkOutput("reset.result_valid", int'(rvA), 0);
    checkOutput("reset.result", int'(resA), 0);
    checkOutput("reset.yes_cnt", int'(yesA), 0);
    checkOutput("reset.no_quorum", int'(nqA), 0);
    rst = 1'b0;

    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("idle_ballot.err", int'(errA), 0);
    checkOutput("idle_ballot.yes_cnt", int'(yesA), 0);

    // Session 1: 3 yes, 1 no, closes on all voted
    pulseStart();
    checkOutput("s1.ready", int'(readyA), 1);
    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("s1.yes_after_first", int'(yesA), 1);
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd2, 1'b1, 1'b0);
    applyStimulus(2'd3, 1'b0, 1'b0);
    checkOutput("s1.yes_cnt", int'(yesA), 3);
    checkOutput("s1.no_cnt", int'(noA), 1);
    checkOutput("s1.ready_in_eval", int'(readyA), 0);
    checkOutput("s1.valid_in_eval", int'(rvA), 0);
    tick();
    checkOutput("s1.valid", int'(rvA), 1);
    checkOutput("s1.maj_result", int'(resA), int'(RES_PASS));
    checkOutput("s1.maj_no_quorum", int'(nqA), 0);
    checkOutput("s1.unan_result", int'(resB), int'(RES_FAIL));
    checkOutput("s1.thr_result", int'(resC), int'(RES_PASS));

    // Session 2: 2 yes, 2 no, with a duplicate ballot from id 1
    pulseStart();
    checkOutput("s2.valid_cleared", int'(rvA), 0);
    checkOutput("s2.result_cleared", int'(resA), 0);
    checkOutput("s2.yes_cleared", int'(yesA), 0);
    applyStimulus(2'd0, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b0);
    checkOutput("s2.dup_err", int'(errA), 1);
    checkOutput("s2.dup_yes_cnt", int'(yesA), 2);
    applyStimulus(2'd2, 1'b0, 1'b0);
    checkOutput("s2.err_pulse_end", int'(errA), 0);
    checkOutput("s2.no_cnt", int'(noA), 1);
    applyStimulus(2'd3, 1'b0, 1'b0);
    tick();
    checkOutput("s2.maj_tie", int'(resA), int'(RES_TIE));
    checkOutput("s2.unan_result", int'(resB), int'(RES_FAIL));
    checkOutput("s2.thr_result", int'(resC), int'(RES_PASS));

    // Session 3: unanimous yes
    pulseStart();
    for (int i = 0; i < 4; i++) applyStimulus(2'(i), 1'b1, 1'b0);
    tick();
    checkOutput("s3.unan_pass", int'(resB), int'(RES_PASS));
    checkOutput("s3.maj_pass", int'(resA), int'(RES_PASS));

    // Session 4: close in the same cycle as the second ballot, below quorum
    pulseStart();
    applyStimulus(2'd0, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b1);
    checkOutput("s4.ballot_with_close", int'(yesA), 2);
    checkOutput("s4.valid_t1", int'(rvA), 0);
    tick();
    checkOutput("s4.valid_t2", int'(rvA), 1);
    checkOutput("s4.result", int'(resA), int'(RES_FAIL));
    checkOutput("s4.no_quorum", int'(nqA), 1);
    checkOutput("s4.thr_no_quorum_result", int'(resC), int'(RES_FAIL));
    checkOutput("s4.thr_no_quorum", int'(nqC), 1);

    // Session 5: one ballot then idle until the 8-cycle timeout on instance A only
    pulseStart();
    applyStimulus(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("s5.ready_before_timeout", int'(readyA), 1);
    tick();
    checkOutput("s5.ready_in_eval", int'(readyA), 0);
    checkOutput("s5.valid_in_eval", int'(rvA), 0);
    tick();
    checkOutput("s5.valid", int'(rvA), 1);
    checkOutput("s5.result", int'(resA), int'(RES_FAIL));
    checkOutput("s5.no_quorum", int'(nqA), 1);
    checkOutput("s5.long_timeout_still_open", int'(readyB), 1);
    closeReq = 1'b1;
    tick();
    closeReq = 1'b0;
    checkOutput("s5.close_in_done_ignored", int'(rvA), 1);
    tick();
    checkOutput("s5.closed_valid", int'(rvB), 1);

    // Instance D (N=5): reset mid-session, then an out-of-range id
    startD = 1'b1;
    tick();
    startD = 1'b0;
    applyStimulusD(3'd0, 1'b1);
    applyStimulusD(3'd1, 1'b0);
    checkOutput("d.yes_before_rst", int'(yesD), 1);
    checkOutput("d.no_before_rst", int'(noD), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("d.rst_yes", int'(yesD), 0);
    checkOutput("d.rst_no", int'(noD), 0);
    checkOutput("d.rst_ready", int'(readyD), 0);
    checkOutput("d.rst_other_valid", int'(rvA), 0);
    applyStimulusD(3'd2, 1'b1);
    checkOutput("d.idle_ballot_yes", int'(yesD), 0);
    checkOutput("d.idle_ballot_err", int'(errD), 0);
    startD = 1'b1;
    tick();
    startD = 1'b0;
    checkOutput("d.ready", int'(readyD), 1);
    applyStimulusD(3'd5, 1'b1);
    checkOutput("d.range_err", int'(errD), 1);
    checkOutput("d.range_yes", int'(yesD), 0);
    applyStimulusD(3'd4, 1'b1);
    checkOutput("d.top_id_err", int'(errD), 0);
    checkOutput("d.top_id_yes", int'(yesD), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
